can_error_frame_ctrl: RTL and testbench
=======================================

# can_error_frame_ctrl

Sequences the CAN error frame that follows any detected protocol error, and generates the fault-confinement increment codes consumed by the error control unit's TEC/REC counters. On an error request it drives an active or passive error flag according to the current error state. It then absorbs superimposed dominant bits, checks the error delimiter and issues `tx_code`/`rx_code` pulses. It sits between the bit-timing logic (`bit_tick`, sampled bus bit) and the error control unit (`start_err_tx`, `error_state`, code inputs).

## Interface
Parameters:
- `FLAG_LEN`, 6: error flag length in bits.
- `DELIM_LEN`, 8: error delimiter length in recessive bits.
- `DOM_LIMIT`, 8: consecutive dominant bits after the flag per extra +8 penalty.

Ports:
- `clk` in 1: system clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `bit_tick` in 1: one-`clk` pulse per bit time. All bit-level actions occur on `clk` edges where `bit_tick`=1.
- `start_err` in 1: error detected (level or pulse). Latched while IDLE.
- `is_tx` in 1: node is the current transmitter. Sampled when FLAG is entered.
- `error_state` in 2: 00 = error-active, x1 = error-passive, 1x = bus-off.
- `rx_bit` in 1: sampled bus value of the bit period ending at this `bit_tick` (1 = recessive).
- `tx_bit` out 1: bus drive for the next bit period (1 = recessive).
- `err_busy` out 1: high whenever state is not IDLE or a request is pending.
- `tx_code` out 2: TEC code (00 none, 01 +1, 10 +8, 11 -1). This block emits only 00/10.
- `rx_code` out 2: REC code, same encoding. This block emits only 00/01/10.
- `frame_done` out 1: one-`clk` pulse when the delimiter completes.

## Operation
- States: IDLE, FLAG, ECHO, DELIM.
- IDLE: `start_err`=1 sets `pend`, unless `error_state[1]`=1 (bus-off), which ignores the request. On the next `bit_tick` with `pend`=1:
  - go to FLAG, clear `pend`, `cnt`=0, latch `role`=`is_tx` and `passive`=`error_state[0]`.
  - `tx_bit`=`passive`.
  - entry code: `tx_code`=10 if `role`, else `rx_code`=01.
- FLAG, each tick:
  - Active flag only: if `rx_bit`=1 (bit error on own dominant flag), issue an extra 10 on the role's code.
  - `cnt`++.
  - After the FLAG_LEN-th tick, go to ECHO with `tx_bit`=1, `domcnt`=0, `first`=1.
- ECHO, each tick:
  - `rx_bit`=1: go to DELIM with `cnt`=1, since this bit is delimiter bit 1.
  - `rx_bit`=0:
    - if `first` and !`role`, issue `rx_code`=10.
    - `domcnt`++. When `domcnt` reaches DOM_LIMIT, issue 10 on the role's code and set `domcnt`=0.
  - `first`=0 after any ECHO tick.
- DELIM, each tick:
  - `rx_bit`=1: `cnt`++. When `cnt`==DELIM_LEN, go to IDLE and pulse `frame_done`.
  - `rx_bit`=0 (form error): restart FLAG exactly as an IDLE entry, including the entry code, with fresh `role`/`passive`.
- `start_err` while not IDLE: ignored; `pend` is not set.
- Bus-off (`error_state[1]`=1) in any state:
  - on the next `clk`, go to IDLE with `tx_bit`=1;
  - clear `pend`, codes and `domcnt`;
  - no `frame_done`.
- Simultaneous events: if the same tick would issue both a DOM_LIMIT penalty and a `first` penalty on `rx_code`, output 10 once. Codes never sum.
- Counter widths:
  - `cnt` is wide enough for max(FLAG_LEN, DELIM_LEN).
  - `domcnt` is wide enough for DOM_LIMIT. It wraps only via the explicit clear at DOM_LIMIT.

## Timing
- Reset values:
  - state IDLE, `pend`=0;
  - `tx_bit`=1, `err_busy`=0, `tx_code`=00, `rx_code`=00, `frame_done`=0;
  - all counters 0.
- `pend` sets on the `clk` edge after `start_err`. `err_busy` is registered and rises in that same cycle.
- The first flag bit is driven from the first `bit_tick` edge after `pend` sets. The minimum latency is 1 `clk` if `bit_tick` is coincident with `pend`.
- Codes are registered. They are set on a `bit_tick` edge and held exactly one bit period, returning to 00 on the next `bit_tick` edge. The error control unit therefore sees each code across one full bit-strobe.
- Fault-free frame length: FLAG_LEN + DELIM_LEN bit periods from the first flag bit to `frame_done`.
- `frame_done` and the return to IDLE (`err_busy` low) occur on the same edge. A new `start_err` may be latched from the following `clk`.

## Test plan
- Active receiver, error-free bus:
  - stimulus: `start_err`, `is_tx`=0, `error_state`=00, then bus reads 6 dominant followed by 8 recessive.
  - response: `tx_bit`=0 for 6 bits then 1; `rx_code`=01 for one bit at entry, no other codes; `frame_done` after 14 bit ticks.
- Passive transmitter:
  - stimulus: `is_tx`=1, `error_state`=01.
  - response: `tx_bit` stays 1 throughout; `tx_code`=10 once at entry; `rx_code` stays 00.
- Superposition, receiver:
  - stimulus: after the flag, the bus stays dominant for 17 bits, then goes recessive.
  - response: `rx_code`=10 on the first ECHO bit, again on the 8th and 16th dominant bits (3 total); delimiter completes 8 bits after the first recessive.
- Delimiter form error:
  - stimulus: dominant `rx_bit` at delimiter bit 4.
  - response: FLAG restarts, `tx_bit`=0 on the next bit, entry code reissued, `frame_done` suppressed until the second delimiter completes.
- Bus-off abort:
  - stimulus: `error_state`=10 asserted mid-FLAG.
  - response: IDLE and `tx_bit`=1 on the next `clk`, no codes, no `frame_done`; a subsequent `start_err` is ignored.
- Reset mid-ECHO:
  - stimulus: assert `nRST`=0 asynchronously during ECHO.
  - response: all outputs take their reset values immediately, without waiting for `clk`.

Source files
------------

// File: rtl/can_error_frame_ctrl.sv
// rtl/can_error_frame_ctrl.sv - CAN error frame sequencer with TEC/REC increment codes
module can_error_frame_ctrl #(
    parameter int FLAG_LEN  = 6,
    parameter int DELIM_LEN = 8,
    parameter int DOM_LIMIT = 8
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       bit_tick,
    input  logic       start_err,
    input  logic       is_tx,
    input  logic [1:0] error_state,
    input  logic       rx_bit,
    output logic       tx_bit,
    output logic       err_busy,
    output logic [1:0] tx_code,
    output logic [1:0] rx_code,
    output logic       frame_done
);

    localparam int CNT_MAX = (FLAG_LEN > DELIM_LEN) ? FLAG_LEN : DELIM_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DOM_W   = $clog2(DOM_LIMIT + 1);

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_P1   = 2'b01;
    localparam logic [1:0] CODE_P8   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FLAG  = 2'd1,
        S_ECHO  = 2'd2,
        S_DELIM = 2'd3
    } state_e;

    state_e             state_q,      state_d;
    logic               pend_q,       pend_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [DOM_W-1:0]   domcnt_q,     domcnt_d;
    logic               role_q,       role_d;
    logic               passive_q,    passive_d;
    logic               first_q,      first_d;
    logic               tx_bit_q,     tx_bit_d;
    logic               busy_q,       busy_d;
    logic [1:0]         tx_code_q,    tx_code_d;
    logic [1:0]         rx_code_q,    rx_code_d;
    logic               frame_done_q, frame_done_d;

    logic               enter_flag;
    logic               role_pen;
    logic [CNT_W-1:0]   cnt_inc;
    logic [DOM_W-1:0]   domcnt_inc;

    assign cnt_inc    = cnt_q + CNT_W'(1);
    assign domcnt_inc = domcnt_q + DOM_W'(1);

    // State and output registers; reset forces the idle, recessive, no-code state.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q      <= S_IDLE;
            pend_q       <= 1'b0;
            cnt_q        <= '0;
            domcnt_q     <= '0;
            role_q       <= 1'b0;
            passive_q    <= 1'b0;
            first_q      <= 1'b0;
            tx_bit_q     <= 1'b1;
            busy_q       <= 1'b0;
            tx_code_q    <= CODE_NONE;
            rx_code_q    <= CODE_NONE;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            cnt_q        <= cnt_d;
            domcnt_q     <= domcnt_d;
            role_q       <= role_d;
            passive_q    <= passive_d;
            first_q      <= first_d;
            tx_bit_q     <= tx_bit_d;
            busy_q       <= busy_d;
            tx_code_q    <= tx_code_d;
            rx_code_q    <= rx_code_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Next-state logic: codes live for one bit period, bus-off overrides everything.
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        cnt_d        = cnt_q;
        domcnt_d     = domcnt_q;
        role_d       = role_q;
        passive_d    = passive_q;
        first_d      = first_q;
        tx_bit_d     = tx_bit_q;
        tx_code_d    = bit_tick ? CODE_NONE : tx_code_q;
        rx_code_d    = bit_tick ? CODE_NONE : rx_code_q;
        frame_done_d = 1'b0;
        enter_flag   = 1'b0;
        role_pen     = 1'b0;

        if (error_state[1]) begin
            state_d   = S_IDLE;
            pend_d    = 1'b0;
            cnt_d     = '0;
            domcnt_d  = '0;
            first_d   = 1'b0;
            tx_bit_d  = 1'b1;
            tx_code_d = CODE_NONE;
            rx_code_d = CODE_NONE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    tx_bit_d = 1'b1;
                    if (start_err) begin
                        pend_d = 1'b1;
                    end
                    if (bit_tick && pend_q) begin
                        enter_flag = 1'b1;
                    end
                end
                S_FLAG: begin
                    if (bit_tick) begin
                        // Reading recessive on our own dominant flag is a bit error.
                        if (!passive_q && rx_bit) begin
                            role_pen = 1'b1;
                        end
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(FLAG_LEN)) begin
                            state_d  = S_ECHO;
                            tx_bit_d = 1'b1;
                            domcnt_d = '0;
                            first_d  = 1'b1;
                        end
                    end
                end
                S_ECHO: begin
                    if (bit_tick) begin
                        first_d = 1'b0;
                        if (rx_bit) begin
                            // This recessive bit already counts as delimiter bit 1.
                            state_d = S_DELIM;
                            cnt_d   = CNT_W'(1);
                        end else begin
                            if (first_q && !role_q) begin
                                rx_code_d = CODE_P8;
                            end
                            if (domcnt_inc == DOM_W'(DOM_LIMIT)) begin
                                role_pen = 1'b1;
                                domcnt_d = '0;
                            end else begin
                                domcnt_d = domcnt_inc;
                            end
                        end
                    end
                end
                S_DELIM: begin
                    if (bit_tick) begin
                        if (rx_bit) begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == CNT_W'(DELIM_LEN)) begin
                                state_d      = S_IDLE;
                                frame_done_d = 1'b1;
                            end
                        end else begin
                            // Form error in the delimiter: start a fresh error frame.
                            enter_flag = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase

            if (enter_flag) begin
                state_d   = S_FLAG;
                pend_d    = 1'b0;
                cnt_d     = '0;
                role_d    = is_tx;
                passive_d = error_state[0];
                tx_bit_d  = error_state[0];
                if (is_tx) begin
                    tx_code_d = CODE_P8;
                end else begin
                    rx_code_d = CODE_P1;
                end
            end

            // A penalty overwrites rather than adds, so coincident penalties give one +8.
            if (role_pen) begin
                if (role_q) begin
                    tx_code_d = CODE_P8;
                end else begin
                    rx_code_d = CODE_P8;
                end
            end
        end

        busy_d = (state_d != S_IDLE) || pend_d;
    end

    assign tx_bit     = tx_bit_q;
    assign err_busy   = busy_q;
    assign tx_code    = tx_code_q;
    assign rx_code    = rx_code_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_can_error_frame_ctrl.sv
// tb/tb_can_error_frame_ctrl.sv - scoreboard bench for can_error_frame_ctrl
module tb_can_error_frame_ctrl;

    logic       clk = 1'b0;
    logic       nRST;
    logic       bit_tick;
    logic       start_err;
    logic       is_tx;
    logic [1:0] error_state;
    logic       rx_bit;
    logic       tx_bit;
    logic       err_busy;
    logic [1:0] tx_code;
    logic [1:0] rx_code;
    logic       frame_done;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       tx;
        logic [1:0] txc;
        logic [1:0] rxc;
        logic       done;
        logic       busy;
        string      tag;
    } exp_t;

    exp_t sb[$];

    can_error_frame_ctrl #(
        .FLAG_LEN  (6),
        .DELIM_LEN (8),
        .DOM_LIMIT (8)
    ) dut (
        .clk         (clk),
        .nRST        (nRST),
        .bit_tick    (bit_tick),
        .start_err   (start_err),
        .is_tx       (is_tx),
        .error_state (error_state),
        .rx_bit      (rx_bit),
        .tx_bit      (tx_bit),
        .err_busy    (err_busy),
        .tx_code     (tx_code),
        .rx_code     (rx_code),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic etx, input logic [1:0] etc, input logic [1:0] erc,
                            input logic edone, input logic ebusy, input string tag);
        exp_t e;
        e.tx   = etx;
        e.txc  = etc;
        e.rxc  = erc;
        e.done = edone;
        e.busy = ebusy;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            e = sb.pop_front();
            check({e.tag, "/tx_bit"},     32'(tx_bit),     32'(e.tx));
            check({e.tag, "/tx_code"},    32'(tx_code),    32'(e.txc));
            check({e.tag, "/rx_code"},    32'(rx_code),    32'(e.rxc));
            check({e.tag, "/frame_done"}, 32'(frame_done), 32'(e.done));
            check({e.tag, "/err_busy"},   32'(err_busy),   32'(e.busy));
        end
    endtask

    // One bit period: tick edge compared via scoreboard, then a quiet clk checks hold.
    task automatic tick(input logic rx, input logic etx, input logic [1:0] etc, input logic [1:0] erc,
                        input logic edone, input logic ebusy, input string tag);
        push_exp(etx, etc, erc, edone, ebusy, tag);
        @(negedge clk);
        rx_bit   = rx;
        bit_tick = 1'b1;
        @(posedge clk);
        #1;
        bit_tick = 1'b0;
        pop_compare();
        @(posedge clk);
        #1;
        check({tag, "/hold_tx_code"},    32'(tx_code),    32'(etc));
        check({tag, "/hold_rx_code"},    32'(rx_code),    32'(erc));
        check({tag, "/hold_frame_done"}, 32'(frame_done), 32'(0));
    endtask

    task automatic cyc(input logic etx, input logic [1:0] etc, input logic [1:0] erc,
                       input logic edone, input logic ebusy, input string tag);
        push_exp(etx, etc, erc, edone, ebusy, tag);
        @(posedge clk);
        #1;
        pop_compare();
    endtask

    task automatic start_req(input string tag);
        start_err = 1'b1;
        cyc(1'b1, 2'b00, 2'b00, 1'b0, 1'b1, {tag, "_pend"});
        start_err = 1'b0;
    endtask

    // Fault-free tail after the flag: echo bit is delimiter bit 1, then 7 more.
    task automatic clean_delim(input string tag);
        tick(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, {tag, "_echo"});
        for (int i = 2; i <= 8; i++) begin
            tick(1'b1, 1'b1, 2'b00, 2'b00, (i == 8), (i != 8), $sformatf("%s_delim%0d", tag, i));
        end
    endtask

    initial begin
        nRST        = 1'b0;
        bit_tick    = 1'b0;
        start_err   = 1'b0;
        is_tx       = 1'b0;
        error_state = 2'b00;
        rx_bit      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst/tx_bit",     32'(tx_bit),     32'(1));
        check("rst/err_busy",   32'(err_busy),   32'(0));
        check("rst/tx_code",    32'(tx_code),    32'(0));
        check("rst/rx_code",    32'(rx_code),    32'(0));
        check("rst/frame_done", 32'(frame_done), 32'(0));
        @(negedge clk);
        nRST = 1'b1;
        @(posedge clk);
        #1;

        // Active receiver, clean bus
        is_tx = 1'b0;
        error_state = 2'b00;
        start_req("s1");
        tick(1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, "s1_entry");
        for (int i = 1; i <= 6; i++) begin
            tick(1'b0, (i == 6), 2'b00, 2'b00, 1'b0, 1'b1, $sformatf("s1_flag%0d", i));
        end
        clean_delim("s1");

        // Passive transmitter
        is_tx = 1'b1;
        error_state = 2'b01;
        start_req("s2");
        tick(1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 1'b1, "s2_entry");
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, $sformatf("s2_flag%0d", i));
        end
        clean_delim("s2");

        // Superposition, receiver: 17 dominant echo bits
        is_tx = 1'b0;
        error_state = 2'b00;
        start_req("s3");
        tick(1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, "s3_entry");
        for (int i = 1; i <= 6; i++) begin
            tick(1'b0, (i == 6), 2'b00, 2'b00, 1'b0, 1'b1, $sformatf("s3_flag%0d", i));
        end
        for (int i = 1; i <= 17; i++) begin
            tick(1'b0, 1'b1, 2'b00, (i == 1 || i == 8 || i == 16) ? 2'b10 : 2'b00,
                 1'b0, 1'b1, $sformatf("s3_dom%0d", i));
        end
        clean_delim("s3");

        // Active transmitter, flag bit error, then delimiter form error at bit 4
        is_tx = 1'b1;
        error_state = 2'b00;
        start_req("s4");
        tick(1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, "s4_entry");
        for (int i = 1; i <= 6; i++) begin
            tick((i == 3), (i == 6), (i == 3) ? 2'b10 : 2'b00, 2'b00, 1'b0, 1'b1,
                 $sformatf("s4_flag%0d", i));
        end
        tick(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, "s4_echo");
        tick(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, "s4_delim2");
        tick(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, "s4_delim3");
        is_tx = 1'b0;
        tick(1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, "s4_restart");
        for (int i = 1; i <= 6; i++) begin
            tick(1'b0, (i == 6), 2'b00, 2'b00, 1'b0, 1'b1, $sformatf("s4_reflag%0d", i));
        end
        clean_delim("s4r");

        // Bus-off mid-flag while a code is being held
        is_tx = 1'b1;
        error_state = 2'b00;
        start_req("s5");
        tick(1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, "s5_entry");
        tick(1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, "s5_flag1");
        tick(1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b1, "s5_flag2");
        error_state = 2'b10;
        cyc(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "s5_busoff");
        start_err = 1'b1;
        cyc(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "s5_ignored");
        start_err = 1'b0;
        tick(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "s5_idle1");
        error_state = 2'b00;
        tick(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "s5_idle2");

        // Asynchronous reset during echo
        is_tx = 1'b0;
        start_req("s6");
        tick(1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, "s6_entry");
        for (int i = 1; i <= 6; i++) begin
            tick(1'b0, (i == 6), 2'b00, 2'b00, 1'b0, 1'b1, $sformatf("s6_flag%0d", i));
        end
        tick(1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 1'b1, "s6_dom1");
        tick(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, "s6_dom2");
        #2;
        nRST = 1'b0;
        #1;
        check("s6_rst/tx_bit",     32'(tx_bit),     32'(1));
        check("s6_rst/err_busy",   32'(err_busy),   32'(0));
        check("s6_rst/tx_code",    32'(tx_code),    32'(0));
        check("s6_rst/rx_code",    32'(rx_code),    32'(0));
        check("s6_rst/frame_done", 32'(frame_done), 32'(0));
        @(negedge clk);
        nRST = 1'b1;
        tick(1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, "s6_after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
